// File: rtl/ssp_param.sv
// Parametrised synchronous serial port: APB-style register slave, TI-style
// frame-synchronised serial transmitter (master) and receiver (slave).

module ssp_param_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == CW'(0));
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_data  = r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO still accepts a push when the same cycle pops.
    assign w_push  = i_push && (!o_full || w_pop);

    // Storage write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wptr  <= AW'(0);
            r_rptr  <= AW'(0);
            r_count <= CW'(0);
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module ssp_param #(
    parameter int WORD_SIZE = 8,
    parameter int DEPTH     = 4,
    parameter int DIV_W     = 8
) (
    input  logic                 PCLK,
    input  logic                 CLEAR,
    input  logic                 PSEL,
    input  logic                 PWRITE,
    input  logic [1:0]           PADDR,
    input  logic [WORD_SIZE-1:0] PWDATA,
    output logic [WORD_SIZE-1:0] PRDATA,
    input  logic                 SSPCLKIN,
    input  logic                 SSPFSSIN,
    input  logic                 SSPRXD,
    output logic                 SSPOE_B,
    output logic                 SSPTXD,
    output logic                 SSPCLKOUT,
    output logic                 SSPFSSOUT,
    output logic                 SSPTXINTR,
    output logic                 SSPRXINTR
);
    localparam int BW = $clog2(WORD_SIZE);
    localparam int SW = (WORD_SIZE > 6) ? WORD_SIZE : 6;

    typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_DATA} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_PUSH} rx_state_t;

    logic                 r_en;
    logic                 r_loop;
    logic [DIV_W-1:0]     r_clkdiv;
    logic [DIV_W-1:0]     r_div_cnt;
    logic                 r_sclk;
    logic                 r_overrun;
    logic [WORD_SIZE-1:0] r_prdata;
    logic                 r_txintr;
    logic                 r_rxintr;

    tx_state_t            r_tx_state;
    logic [BW-1:0]        r_tx_bit;
    logic [WORD_SIZE-1:0] r_tx_shift;
    logic                 r_tx_chain;
    logic                 r_fss;
    logic                 r_oe_b;
    logic                 r_txd;

    logic [1:0]           r_sync_clk;
    logic [1:0]           r_sync_fss;
    logic [1:0]           r_sync_dat;
    logic                 r_src_clk_d;
    rx_state_t            r_rx_state;
    logic [BW-1:0]        r_rx_cnt;
    logic [WORD_SIZE-1:0] r_rx_shift;
    logic                 r_rx_fss_last;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_stat_rd;
    logic                 w_tx_push;
    logic                 w_tx_pop;
    logic                 w_tx_empty;
    logic                 w_tx_full;
    logic [WORD_SIZE-1:0] w_tx_head;
    logic                 w_rx_push;
    logic                 w_rx_pop;
    logic                 w_rx_pop_ok;
    logic                 w_rx_drop;
    logic                 w_rx_empty;
    logic                 w_rx_full;
    logic [WORD_SIZE-1:0] w_rx_head;
    logic                 w_div_hit;
    logic                 w_sclk_rise;
    logic                 w_src_clk;
    logic                 w_src_fss;
    logic                 w_src_data;
    logic                 w_src_fall;
    logic                 w_busy;
    logic [SW-1:0]        w_status_ext;
    logic [WORD_SIZE-1:0] w_status;
    logic [WORD_SIZE-1:0] w_rd_data;

    assign w_wr      = PSEL && PWRITE;
    assign w_rd      = PSEL && !PWRITE;
    assign w_stat_rd = w_rd && (PADDR == 2'd3);
    assign w_tx_push = w_wr && (PADDR == 2'd0);
    assign w_rx_pop  = w_rd && (PADDR == 2'd0);

    assign w_div_hit   = (r_div_cnt >= r_clkdiv);
    assign w_sclk_rise = r_en && w_div_hit && !r_sclk;
    // Words leave the TX FIFO at frame start, or while the last bit goes out.
    assign w_tx_pop    = w_sclk_rise && !w_tx_empty &&
                         ((r_tx_state == TX_IDLE) ||
                          ((r_tx_state == TX_DATA) && (r_tx_bit == BW'(1))));

    assign w_src_clk   = r_loop ? r_sclk : r_sync_clk[1];
    assign w_src_fss   = r_loop ? r_fss  : r_sync_fss[1];
    assign w_src_data  = r_loop ? r_txd  : r_sync_dat[1];
    assign w_src_fall  = r_src_clk_d && !w_src_clk;

    assign w_rx_push   = (r_rx_state == RX_PUSH);
    assign w_rx_pop_ok = w_rx_pop && !w_rx_empty;
    assign w_rx_drop   = w_rx_push && w_rx_full && !w_rx_pop_ok;

    assign w_busy       = (r_tx_state != TX_IDLE);
    assign w_status_ext = SW'({r_overrun, w_busy, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty});
    assign w_status     = w_status_ext[WORD_SIZE-1:0];

    ssp_param_fifo #(.WIDTH(WORD_SIZE), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (PCLK),
        .srst    (CLEAR),
        .i_push  (w_tx_push),
        .i_data  (PWDATA),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    ssp_param_fifo #(.WIDTH(WORD_SIZE), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (PCLK),
        .srst    (CLEAR),
        .i_push  (w_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_data  (w_rx_head),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    // Register read multiplexer
    always_comb begin
        w_rd_data = '0;
        case (PADDR)
            2'd0:    w_rd_data = w_rx_empty ? '0 : w_rx_head;
            2'd1:    w_rd_data = WORD_SIZE'({r_loop, r_en});
            2'd2:    w_rd_data = WORD_SIZE'(r_clkdiv);
            2'd3:    w_rd_data = w_status;
            default: w_rd_data = '0;
        endcase
    end

    // Control registers, read data and sticky overrun
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            r_en      <= 1'b0;
            r_loop    <= 1'b0;
            r_clkdiv  <= DIV_W'(0);
            r_prdata  <= '0;
            r_overrun <= 1'b0;
            r_txintr  <= 1'b0;
            r_rxintr  <= 1'b0;
        end else begin
            if (w_wr && (PADDR == 2'd1)) begin
                r_en   <= PWDATA[0];
                r_loop <= PWDATA[1];
            end
            if (w_wr && (PADDR == 2'd2)) begin
                r_clkdiv <= PWDATA[DIV_W-1:0];
            end
            if (w_rd) begin
                r_prdata <= w_rd_data;
            end
            // A drop in the same cycle as a STATUS read must not be lost.
            if (w_rx_drop) begin
                r_overrun <= 1'b1;
            end else if (w_stat_rd) begin
                r_overrun <= 1'b0;
            end
            r_txintr <= w_tx_full;
            r_rxintr <= w_rx_full;
        end
    end

    // Serial clock divider
    always_ff @(posedge PCLK) begin
        if (CLEAR || !r_en) begin
            r_div_cnt <= DIV_W'(0);
            r_sclk    <= 1'b0;
        end else if (w_div_hit) begin
            r_div_cnt <= DIV_W'(0);
            r_sclk    <= !r_sclk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Transmit FSM, advancing on serial clock rising edges
    always_ff @(posedge PCLK) begin
        if (CLEAR || !r_en) begin
            r_tx_state <= TX_IDLE;
            r_tx_bit   <= BW'(0);
            r_tx_shift <= '0;
            r_tx_chain <= 1'b0;
            r_fss      <= 1'b0;
            r_oe_b     <= 1'b1;
            r_txd      <= 1'b0;
        end else if (w_sclk_rise) begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_shift <= w_tx_head;
                        r_tx_state <= TX_SYNC;
                        r_fss      <= 1'b1;
                    end
                end
                TX_SYNC: begin
                    r_tx_state <= TX_DATA;
                    r_tx_bit   <= BW'(WORD_SIZE - 1);
                    r_oe_b     <= 1'b0;
                    r_txd      <= r_tx_shift[WORD_SIZE-1];
                    r_fss      <= 1'b0;
                end
                TX_DATA: begin
                    if (r_tx_bit == BW'(1)) begin
                        // Bit 0 is latched into r_txd, so the shifter is free for the next word.
                        r_tx_bit <= BW'(0);
                        r_txd    <= r_tx_shift[0];
                        if (w_tx_pop) begin
                            r_tx_shift <= w_tx_head;
                            r_fss      <= 1'b1;
                            r_tx_chain <= 1'b1;
                        end
                    end else if (r_tx_bit == BW'(0)) begin
                        r_fss <= 1'b0;
                        if (r_tx_chain) begin
                            r_tx_chain <= 1'b0;
                            r_tx_bit   <= BW'(WORD_SIZE - 1);
                            r_txd      <= r_tx_shift[WORD_SIZE-1];
                        end else begin
                            r_tx_state <= TX_IDLE;
                            r_oe_b     <= 1'b1;
                            r_txd      <= 1'b0;
                        end
                    end else begin
                        r_tx_bit <= r_tx_bit - BW'(1);
                        r_txd    <= r_tx_shift[r_tx_bit - BW'(1)];
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_oe_b     <= 1'b1;
                    r_txd      <= 1'b0;
                    r_fss      <= 1'b0;
                end
            endcase
        end
    end

    // External receive synchronisers and source clock edge history
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            r_sync_clk  <= 2'b00;
            r_sync_fss  <= 2'b00;
            r_sync_dat  <= 2'b00;
            r_src_clk_d <= 1'b0;
        end else begin
            r_sync_clk  <= {r_sync_clk[0], SSPCLKIN};
            r_sync_fss  <= {r_sync_fss[0], SSPFSSIN};
            r_sync_dat  <= {r_sync_dat[0], SSPRXD};
            r_src_clk_d <= w_src_clk;
        end
    end

    // Receive FSM, sampling on source clock falling edges
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            r_rx_state    <= RX_IDLE;
            r_rx_cnt      <= BW'(0);
            r_rx_shift    <= '0;
            r_rx_fss_last <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_src_fall && w_src_fss) begin
                        r_rx_state <= RX_SHIFT;
                        r_rx_cnt   <= BW'(0);
                    end
                end
                RX_SHIFT: begin
                    if (w_src_fall) begin
                        r_rx_shift <= {r_rx_shift[WORD_SIZE-2:0], w_src_data};
                        if (r_rx_cnt == BW'(WORD_SIZE - 1)) begin
                            r_rx_state    <= RX_PUSH;
                            r_rx_fss_last <= w_src_fss;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + BW'(1);
                        end
                    end
                end
                RX_PUSH: begin
                    r_rx_cnt   <= BW'(0);
                    r_rx_state <= r_rx_fss_last ? RX_SHIFT : RX_IDLE;
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign PRDATA    = r_prdata;
    assign SSPOE_B   = r_oe_b;
    assign SSPTXD    = r_txd;
    assign SSPCLKOUT = r_sclk;
    assign SSPFSSOUT = r_fss;
    assign SSPTXINTR = r_txintr;
    assign SSPRXINTR = r_rxintr;
endmodule

// File: tb/tb_ssp_param.sv
// Scoreboard bench for ssp_param: a serial-line monitor decodes transmitted
// frames against a queue of expected words; RX reads follow a queue model.

module tb_ssp_param;
    localparam int WS    = 8;
    localparam int DEPTH = 4;

    logic          PCLK = 1'b0;
    logic          CLEAR = 1'b1;
    logic          PSEL = 1'b0;
    logic          PWRITE = 1'b0;
    logic [1:0]    PADDR = 2'd0;
    logic [WS-1:0] PWDATA = '0;
    logic [WS-1:0] PRDATA;
    logic          SSPCLKIN = 1'b0;
    logic          SSPFSSIN = 1'b0;
    logic          SSPRXD = 1'b0;
    logic          SSPOE_B, SSPTXD, SSPCLKOUT, SSPFSSOUT, SSPTXINTR, SSPRXINTR;

    always #5 PCLK = ~PCLK;

    ssp_param #(.WORD_SIZE(WS), .DEPTH(DEPTH), .DIV_W(8)) dut (
        .PCLK(PCLK), .CLEAR(CLEAR), .PSEL(PSEL), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .SSPCLKIN(SSPCLKIN), .SSPFSSIN(SSPFSSIN),
        .SSPRXD(SSPRXD), .SSPOE_B(SSPOE_B), .SSPTXD(SSPTXD), .SSPCLKOUT(SSPCLKOUT),
        .SSPFSSOUT(SSPFSSOUT), .SSPTXINTR(SSPTXINTR), .SSPRXINTR(SSPRXINTR)
    );

    int            n_checks = 0;
    int            n_fail = 0;
    logic [WS-1:0] tx_exp[$];    // words expected to appear on SSPTXD
    logic [WS-1:0] rx_model[$];  // expected RX FIFO contents, oldest first
    bit            mon_en = 1'b1;
    int            last_oe_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Serial monitor: a protocol-level receiver on the TX pins feeding the scoreboard
    initial begin
        int            bits;
        int            oe_run;
        logic          sclk_d;
        logic [WS-1:0] word;
        bits = 0; oe_run = 0; sclk_d = 1'b0; word = '0;
        forever begin
            @(negedge PCLK);
            if (!mon_en || CLEAR) begin
                bits = 0;
            end else if (sclk_d && !SSPCLKOUT) begin
                if (bits > 0) begin
                    check("oe_during_data", SSPOE_B, 0);
                    word = {word[WS-2:0], SSPTXD};
                    bits--;
                    if (bits == 0) begin
                        if (tx_exp.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL serial_word: got 0x%0h, expected no frame", word);
                        end else begin
                            check("serial_word", word, tx_exp.pop_front());
                        end
                    end
                end
                if (bits == 0 && SSPFSSOUT) bits = WS;
            end
            sclk_d = SSPCLKOUT;
            if (!SSPOE_B) oe_run++;
            else begin
                if (oe_run > 0) last_oe_run = oe_run;
                oe_run = 0;
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [WS-1:0] d);
        @(negedge PCLK); PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK); PSEL = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [WS-1:0] d);
        @(negedge PCLK); PSEL = 1'b1; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK); d = PRDATA; PSEL = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [WS-1:0] exp);
        logic [WS-1:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic drain_rx(input int n);
        for (int i = 0; i < n; i++) begin
            if (rx_model.size() > 0) read_check("rx_data", 2'd0, rx_model.pop_front());
        end
    endtask

    task automatic wait_serial(input int max_cyc);
        int n;
        n = 0;
        while (tx_exp.size() != 0 && n < max_cyc) begin
            @(negedge PCLK); n++;
        end
        n_checks++;
        if (tx_exp.size() != 0) begin
            n_fail++;
            $display("FAIL serial_timeout: %0d words pending after %0d cycles", tx_exp.size(), max_cyc);
            tx_exp.delete();
        end
        repeat (12) @(negedge PCLK);
    endtask

    task automatic ext_frame(input logic [WS-1:0] d);
        SSPCLKIN = 1'b1; SSPFSSIN = 1'b1; repeat (4) @(negedge PCLK);
        SSPCLKIN = 1'b0; repeat (4) @(negedge PCLK);
        SSPFSSIN = 1'b0;
        for (int i = WS - 1; i >= 0; i--) begin
            SSPCLKIN = 1'b1; SSPRXD = d[i]; repeat (4) @(negedge PCLK);
            SSPCLKIN = 1'b0; repeat (4) @(negedge PCLK);
        end
        SSPRXD = 1'b0;
    endtask

    task automatic sclk_period(output int per);
        int   t0;
        logic prev;
        t0 = -1; per = -1; prev = SSPCLKOUT;
        for (int n = 0; n < 100; n++) begin
            @(negedge PCLK);
            if (!prev && SSPCLKOUT) begin
                if (t0 < 0) t0 = n;
                else begin per = n - t0; break; end
            end
            prev = SSPCLKOUT;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_prdata"}, PRDATA, 0);
        check({tag, "_oe_b"}, SSPOE_B, 1);
        check({tag, "_txd"}, SSPTXD, 0);
        check({tag, "_clkout"}, SSPCLKOUT, 0);
        check({tag, "_fssout"}, SSPFSSOUT, 0);
        check({tag, "_txintr"}, SSPTXINTR, 0);
        check({tag, "_rxintr"}, SSPRXINTR, 0);
    endtask

    initial begin
        logic [WS-1:0] w;
        int            per;
        int            n;
        int            div;
        int            k;

        // Reset state
        repeat (2) @(negedge PCLK);
        check_reset_outputs("reset");
        CLEAR = 1'b0;
        read_check("status_reset", 2'd3, 8'h05);
        read_check("ctrl_reset", 2'd1, 8'h00);
        read_check("clkdiv_reset", 2'd2, 8'h00);
        read_check("rx_empty_read", 2'd0, 8'h00);

        // Register access rules
        bus_write(2'd1, 8'hFE);
        read_check("ctrl_readback", 2'd1, 8'h02);
        bus_write(2'd2, 8'h5A);
        read_check("clkdiv_readback", 2'd2, 8'h5A);
        bus_write(2'd3, 8'hFF);
        read_check("status_write_ignored", 2'd3, 8'h05);
        bus_write(2'd1, 8'h00);
        bus_write(2'd2, 8'h00);

        // Single loopback frame at CLKDIV=0
        bus_write(2'd1, 8'h03);
        last_oe_run = 0;
        tx_exp.push_back(8'hA5); rx_model.push_back(8'hA5);
        bus_write(2'd0, 8'hA5);
        wait_serial(200);
        check("oe_low_single", last_oe_run, 16);
        drain_rx(1);
        read_check("status_after_single", 2'd3, 8'h05);

        // Fill TX with EN=0, 5th write dropped, then back-to-back frames
        bus_write(2'd1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            w = 8'($urandom);
            bus_write(2'd0, w);
            if (i < DEPTH) begin
                tx_exp.push_back(w); rx_model.push_back(w);
            end
            if (i == 2) begin @(negedge PCLK); check("txintr_not_full", SSPTXINTR, 0); end
            if (i == 3) begin @(negedge PCLK); check("txintr_full", SSPTXINTR, 1); end
        end
        read_check("status_tx_full", 2'd3, 8'h06);
        last_oe_run = 0;
        bus_write(2'd1, 8'h03);
        wait_serial(600);
        check("oe_low_back_to_back", last_oe_run, 64);
        check("rxintr_full", SSPRXINTR, 1);
        drain_rx(DEPTH);
        read_check("status_after_b2b", 2'd3, 8'h05);

        // RX overrun: five loopback frames, no reads in between
        bus_write(2'd1, 8'h02);
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom);
            tx_exp.push_back(w); rx_model.push_back(w);
            bus_write(2'd0, w);
        end
        bus_write(2'd1, 8'h03);
        repeat (20) @(negedge PCLK);
        w = 8'($urandom);
        tx_exp.push_back(w);
        bus_write(2'd0, w);
        wait_serial(800);
        check("rxintr_overrun", SSPRXINTR, 1);
        // tx_empty, rx_full and the sticky overrun flag
        read_check("status_overrun", 2'd3, 8'h29);
        read_check("status_overrun_cleared", 2'd3, 8'h09);
        drain_rx(DEPTH);
        read_check("status_drained", 2'd3, 8'h05);

        // External master at PCLK/8
        bus_write(2'd1, 8'h00);
        ext_frame(8'h3C); rx_model.push_back(8'h3C);
        w = 8'($urandom);
        ext_frame(w); rx_model.push_back(w);
        repeat (8) @(negedge PCLK);
        drain_rx(2);
        read_check("status_after_ext", 2'd3, 8'h05);

        // Divider period
        bus_write(2'd2, 8'h03);
        bus_write(2'd1, 8'h01);
        sclk_period(per);
        check("sclk_period_div3", per, 8);
        bus_write(2'd1, 8'h00);
        bus_write(2'd2, 8'h00);

        // EN cleared mid-frame, then CLEAR mid-frame
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(2'd0, 8'($urandom));
        bus_write(2'd1, 8'h01);
        n = 0;
        while (SSPOE_B && n < 100) begin @(negedge PCLK); n++; end
        check("oe_seen_low", SSPOE_B, 0);
        repeat (5) @(negedge PCLK);
        bus_write(2'd1, 8'h00);
        @(negedge PCLK);
        check("abort_oe_b", SSPOE_B, 1);
        check("abort_clkout", SSPCLKOUT, 0);
        read_check("status_abort_kept", 2'd3, 8'h04);
        bus_write(2'd1, 8'h01);
        repeat (6) @(negedge PCLK);
        CLEAR = 1'b1;
        @(negedge PCLK);
        check_reset_outputs("clear_mid");
        CLEAR = 1'b0;
        read_check("status_clear_mid", 2'd3, 8'h05);
        read_check("ctrl_clear_mid", 2'd1, 8'h00);
        tx_exp.delete(); rx_model.delete();
        mon_en = 1'b1;

        // Randomised loopback bursts
        for (int it = 0; it < 6; it++) begin
            div = $urandom_range(0, 3);
            k   = $urandom_range(1, DEPTH);
            bus_write(2'd1, 8'h02);
            bus_write(2'd2, 8'(div));
            for (int i = 0; i < k; i++) begin
                w = 8'($urandom);
                tx_exp.push_back(w); rx_model.push_back(w);
                bus_write(2'd0, w);
            end
            last_oe_run = 0;
            bus_write(2'd1, 8'h03);
            wait_serial(k * 20 * (div + 1) + 100);
            check("oe_low_random", last_oe_run, k * 16 * (div + 1));
            bus_write(2'd1, 8'h00);
            drain_rx(k);
            read_check("status_random", 2'd3, 8'h05);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
